// File: rtl/inner_product_pkg.sv
// Shared types and constant helpers for the inner-product MAC: FSM states, width derivation
// and signed saturation bounds.
package inner_product_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    // Wide enough to hold any accumulator value for the supported parameter ranges.
    localparam int unsigned MaxW = 256;
    typedef logic signed [MaxW-1:0] wide_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned acc_width(input int unsigned w, input int unsigned n);
        return 2 * w + clog2(n);
    endfunction

    // Largest (neg=0) or smallest (neg=1) value representable in a signed out_w-bit result.
    function automatic wide_t sat_bound(input int unsigned out_w, input logic neg);
        wide_t mag;
        mag = wide_t'(1) <<< (out_w - 1);
        return neg ? -mag : mag - wide_t'(1);
    endfunction

endpackage

// File: rtl/ip_lane_sum.sv
// Combinational sum of LANES signed WxW products, sign-extended to the accumulator width.
module ip_lane_sum
    import inner_product_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned LANES = 1,
    parameter int unsigned ACC_W = 66
) (
    input  logic [LANES*W-1:0]       a_i,
    input  logic [LANES*W-1:0]       b_i,
    output logic signed [ACC_W-1:0]  sum_o
);

    logic signed [2*W-1:0] prod [LANES];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign prod[l] = (2*W)'($signed(a_i[l*W +: W])) * (2*W)'($signed(b_i[l*W +: W]));
    end

    always_comb begin
        sum_o = '0;
        for (int l = 0; l < LANES; l++) begin
            sum_o = sum_o + ACC_W'(prod[l]);
        end
    end

endmodule

// File: rtl/inner_product_mac.sv
// Signed inner-product engine with chained accumulation. Define INNER_PRODUCT_SAT_EN to clamp
// the result to the signed OUT_W range and flag it on out_ovf; otherwise the result wraps.
module inner_product_mac
    import inner_product_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned W     = 32,
    parameter int unsigned LANES = 1,
    parameter int unsigned OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*W-1:0]   row,
    input  logic [N*W-1:0]   column,
    input  logic             row_i_stb,
    input  logic             column_i_stb,
    input  logic             acc_mode,
    output logic             row_i_ack,
    output logic             column_i_ack,
    output logic [OUT_W-1:0] out,
    output logic             out_o_stb,
    input  logic             out_o_ack,
    output logic             out_ovf
);

    localparam int unsigned AccW  = acc_width(W, N);
    localparam int unsigned Steps = N / LANES;
    localparam int unsigned CntW  = (Steps > 1) ? clog2(Steps) : 1;

    if ((N % LANES) != 0) begin : g_bad_lanes
        $error("LANES must divide N");
    end
    if (OUT_W > AccW) begin : g_bad_out_w
        $error("OUT_W must not exceed ACC_W");
    end

    state_e                 state_q;
    logic [N*W-1:0]         row_q, col_q;
    logic [CntW-1:0]        cnt_q;
    logic signed [AccW-1:0] acc_q, acc_d, lane_sum;
    logic [LANES*W-1:0]     row_lane, col_lane;
    logic                   ack_q, stb_q, ovf_q, ovf_d;
    logic [OUT_W-1:0]       out_q, out_d;

    assign row_lane = row_q[int'(cnt_q) * LANES * W +: LANES * W];
    assign col_lane = col_q[int'(cnt_q) * LANES * W +: LANES * W];

    ip_lane_sum #(
        .W     (W),
        .LANES (LANES),
        .ACC_W (AccW)
    ) u_lane_sum (
        .a_i   (row_lane),
        .b_i   (col_lane),
        .sum_o (lane_sum)
    );

    assign acc_d = acc_q + lane_sum;

`ifdef INNER_PRODUCT_SAT_EN
    wide_t acc_wide;
    always_comb begin
        acc_wide = wide_t'(acc_d);
        out_d    = acc_d[OUT_W-1:0];
        ovf_d    = 1'b0;
        if (acc_wide > sat_bound(OUT_W, 1'b0)) begin
            out_d = {1'b0, {(OUT_W-1){1'b1}}};
            ovf_d = 1'b1;
        end else if (acc_wide < sat_bound(OUT_W, 1'b1)) begin
            out_d = {1'b1, {(OUT_W-1){1'b0}}};
            ovf_d = 1'b1;
        end
    end
`else
    assign out_d = acc_d[OUT_W-1:0];
    assign ovf_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            ack_q   <= 1'b0;
            stb_q   <= 1'b0;
            ovf_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (row_i_stb && column_i_stb) begin
                        row_q   <= row;
                        col_q   <= column;
                        acc_q   <= acc_mode ? acc_q : '0;
                        cnt_q   <= '0;
                        ack_q   <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(Steps - 1)) begin
                        out_q   <= out_d;
                        ovf_q   <= ovf_d;
                        stb_q   <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (out_o_ack) begin
                        stb_q   <= 1'b0;
                        ovf_q   <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign row_i_ack    = ack_q;
    assign column_i_ack = ack_q;
    assign out          = out_q;
    assign out_o_stb    = stb_q;
    assign out_ovf      = ovf_q;

endmodule
